mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-port arbiter sharing the single mem_ctrl bus (16-bit addr, 8-bit data, read/write strobes, bus_wait).
//  Port A = CPU core, port B = debug/loader.
//  Grants one port per transaction, holds the grant until mem_ctrl completes,
//  then forces a strobe-low release cycle so mem_ctrl never re-launches a stale request.
// PARAMETERS
//  ADDR_WIDTH   16  address width, both ports and downstream
//  DATA_WIDTH   8   data width, both ports and downstream
//  STARVE_LIMIT 4   max consecutive A grants while B is pending before B is forced; 1..15
// PORTS
//  clk           in   1   system clock, single domain
//  rst           in   1   synchronous reset, active-high
//  a_address     in   16  port A address
//  a_data_tx     in   8   port A write data
//  a_read        in   1   port A read request, level
//  a_write       in   1   port A write request, level
//  a_data_rx     out  8   port A read data, valid while a_done=1
//  a_done        out  1   port A completion, 1-cycle pulse
//  b_*           same set as a_*, for port B
//  bus_address   out  16  to mem_ctrl, muxed from granted port
//  bus_data_tx   out  8   to mem_ctrl, muxed from granted port
//  bus_read      out  1   to mem_ctrl
//  bus_write     out  1   to mem_ctrl
//  bus_data_rx   in   8   from mem_ctrl
//  bus_wait      in   1   from mem_ctrl; 0 for exactly one cycle = transaction complete
//  grant_b       out  1   1 = port B owns the bus; debug visibility
// BEHAVIOUR
//  Reset values: a_done=b_done=0, a/b_data_rx=0, bus_read=bus_write=0, grant_b=0, starve count=0, state=IDLE.
//  Reset mid-transaction aborts immediately; no done pulse. mem_ctrl shares rst and restarts alongside.
//  States: IDLE, GRANT, RELEASE.
//  IDLE:
//   - req_x = x_read|x_write.
//   - Neither requesting: stay.
//   - Only one requesting: grant it.
//   - Both requesting: A wins unless starve count == STARVE_LIMIT, then B wins.
//   - Registered grant; -> GRANT. bus strobes rise on the edge after the request is sampled (1-cycle latency).
//  GRANT:
//   - bus_address and bus_data_tx are combinational muxes of the granted port.
//   - bus_write = x_write; bus_read = x_read & ~x_write (write wins if both are set).
//   - Requester must hold address, data and strobe stable until done.
//   - On bus_wait==0: capture bus_data_rx into x_data_rx; next edge: x_done=1, strobes=0, -> RELEASE.
//   - Requester dropping its strobe before done is a protocol violation; behaviour undefined, no recovery.
//  RELEASE (1 cycle):
//   - x_done=1, strobes held 0.
//   - Requester deasserts its request on the edge ending this cycle.
//   - -> IDLE; done returns to 0.
//   - Minimum back-to-back turnaround: IDLE->GRANT->...->RELEASE->IDLE.
//  Starve counter (4 bit):
//   - +1 when A is granted while B is requesting; cleared when B is granted.
//   - Saturates at STARVE_LIMIT.
//  x_data_rx holds its last value until the next completion on that port; for writes it captures whatever mem_ctrl returns.
//  Done is never asserted on the non-granted port.
//  bus_wait is ignored outside GRANT (mem_ctrl idles/dummy-clocks with bus_wait=1).
// CONFIGURATION
//  ARB_FLASH_WP_EN:
//   - Defined: a port-B write with b_address[15]==0 (flash region) is rejected and never reaches mem_ctrl.
//     IDLE grants it, goes directly to RELEASE with b_done=1 and b_data_rx=8'hFF, strobes stay 0.
//     Port-B reads and port-A accesses are unaffected.
//   - Undefined: no address filtering; flash writes pass through.
// TESTING
//  1. A reads 0x8010, model returns 0x5A after 12 cycles -> bus_read=1 one cycle after request;
//     a_data_rx=0x5A and a_done pulses 1 cycle; strobes 0 in RELEASE.
//  2. A and B request in the same cycle, STARVE_LIMIT=4 -> A granted first.
//     With A re-requesting continuously: grants A,A,A,A,B; counter clears after the B grant.
//  3. B writes 0x33 to 0x8100 while A idle -> grant_b=1, bus_write=1, bus_data_tx=0x33, bus_address=0x8100;
//     b_done pulses; a_done stays 0.
//  4. A asserts read and write together -> bus_write=1, bus_read=0 for the whole transaction.
//  5. rst=1 in the middle of GRANT -> next cycle all strobes, dones and grant_b are 0, state IDLE;
//     a later request is served normally.
//  6. ARB_FLASH_WP_EN defined, B writes 0x0200 -> b_done within 2 cycles, b_data_rx=0xFF,
//     bus_write never asserted.
//     Repeat undefined -> normal write to 0x0200.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug-loader) arbiter in front of the single mem_ctrl bus.
// Optional build macro ARB_FLASH_WP_EN rejects port-B writes into the flash region (address MSB = 0).
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0] a_data_tx,
    input  logic                  a_read,
    input  logic                  a_write,
    output logic [DATA_WIDTH-1:0] a_data_rx,
    output logic                  a_done,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0] b_data_tx,
    input  logic                  b_read,
    input  logic                  b_write,
    output logic [DATA_WIDTH-1:0] b_data_rx,
    output logic                  b_done,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_data_tx,
    output logic                  bus_read,
    output logic                  bus_write,
    input  logic [DATA_WIDTH-1:0] bus_data_rx,
    input  logic                  bus_wait,
    output logic                  grant_b
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       req_a;
    logic       req_b;
    logic       pick_b;
    logic       wp_reject;
    logic       sel_read;
    logic       sel_write;

    assign req_a  = a_read | a_write;
    assign req_b  = b_read | b_write;
    // A has priority unless B has already been passed over LIMIT times in a row.
    assign pick_b = req_b & (~req_a | (starve_cnt == LIMIT));

`ifdef ARB_FLASH_WP_EN
    assign wp_reject = b_write & ~b_address[ADDR_WIDTH-1];
`else
    assign wp_reject = 1'b0;
`endif

    assign sel_read    = grant_b ? b_read    : a_read;
    assign sel_write   = grant_b ? b_write   : a_write;
    assign bus_address = grant_b ? b_address : a_address;
    assign bus_data_tx = grant_b ? b_data_tx : a_data_tx;
    // Strobes only live in GRANT so mem_ctrl sees a clean low cycle between transactions.
    assign bus_write   = (state == GRANT) & sel_write;
    assign bus_read    = (state == GRANT) & sel_read & ~sel_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_b    <= 1'b0;
            starve_cnt <= 4'd0;
            a_done     <= 1'b0;
            b_done     <= 1'b0;
            a_data_rx  <= '0;
            b_data_rx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        grant_b <= pick_b;
                        if (pick_b) begin
                            starve_cnt <= 4'd0;
                        end else if (req_b && (starve_cnt < LIMIT)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        if (pick_b && wp_reject) begin
                            b_done    <= 1'b1;
                            b_data_rx <= '1;
                            state     <= RELEASE;
                        end else begin
                            state <= GRANT;
                        end
                    end
                end
                GRANT: begin
                    if (!bus_wait) begin
                        if (grant_b) begin
                            b_data_rx <= bus_data_rx;
                            b_done    <= 1'b1;
                        end else begin
                            a_data_rx <= bus_data_rx;
                            a_done    <= 1'b1;
                        end
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks push expectations, a negedge monitor checks them.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_address, b_address, bus_address;
    logic [7:0]  a_data_tx, b_data_tx, a_data_rx, b_data_rx, bus_data_tx, bus_data_rx;
    logic        a_read, a_write, a_done, b_read, b_write, b_done;
    logic        bus_read, bus_write, bus_wait, grant_b;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_address(a_address), .a_data_tx(a_data_tx), .a_read(a_read), .a_write(a_write),
        .a_data_rx(a_data_rx), .a_done(a_done),
        .b_address(b_address), .b_data_tx(b_data_tx), .b_read(b_read), .b_write(b_write),
        .b_data_rx(b_data_rx), .b_done(b_done),
        .bus_address(bus_address), .bus_data_tx(bus_data_tx), .bus_read(bus_read),
        .bus_write(bus_write), .bus_data_rx(bus_data_rx), .bus_wait(bus_wait),
        .grant_b(grant_b)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rd;
        logic        wr;
        logic [7:0]  rx;
        logic        on_bus;
        logic        seen;
    } txn_t;

    txn_t       qa[$];
    txn_t       qb[$];
    bit         grant_log[$];
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] bus_mem [logic [15:0]];
    int         checks = 0;
    int         failures = 0;
    int         fixed_lat = -1;
    int         mem_cnt = -1;
    int         sc = 0;
    bit         mon_en = 1'b1;
    bit         ps = 1'b0, pra = 1'b0, prb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=no-event", name);
    endtask

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Arbitration rule: A wins a tie unless B has been passed over LIMIT times.
    task automatic service(input bit p, input bit ra, input bit rb);
        bit expb;
        expb = (ra && rb) ? (sc == LIMIT) : !ra;
        chk("arb_winner", 32'(p), 32'(expb));
        grant_log.push_back(p);
        if (p) sc = 0;
        else if (rb && sc < LIMIT) sc++;
    endtask

    // mem_ctrl stand-in: random latency, one-cycle bus_wait low to complete
    initial begin
        bus_wait = 1'b1;
        bus_data_rx = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus_wait = 1'b1;
                mem_cnt = -1;
            end else if (!bus_wait) begin
                bus_wait = 1'b1;
            end else if (bus_read || bus_write) begin
                if (mem_cnt < 0) mem_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
                if (mem_cnt == 0) begin
                    if (bus_write) begin
                        bus_mem[bus_address] = bus_data_tx;
                        bus_data_rx = bus_data_tx ^ 8'hA5;
                    end else begin
                        bus_data_rx = bus_mem.exists(bus_address) ? bus_mem[bus_address] : dflt(bus_address);
                    end
                    bus_wait = 1'b0;
                    mem_cnt = -1;
                end else begin
                    mem_cnt--;
                end
            end else begin
                mem_cnt = -1;
            end
        end
    end

    // monitor
    initial begin
        bit   strobe;
        txn_t e;
        forever begin
            @(negedge clk);
            strobe = bus_read | bus_write;
            if (mon_en && !rst) begin
                if (strobe && !ps) service(grant_b, pra, prb);
                if (strobe) begin
                    if (grant_b ? (qb.size() == 0) : (qa.size() == 0)) begin
                        fail("bus_orphan");
                    end else begin
                        e = grant_b ? qb[0] : qa[0];
                        chk("bus_address", 32'(bus_address), 32'(e.addr));
                        chk("bus_write", 32'(bus_write), 32'(e.wr));
                        chk("bus_read", 32'(bus_read), 32'(e.rd & ~e.wr));
                        if (e.wr) chk("bus_data_tx", 32'(bus_data_tx), 32'(e.data));
                        if (!e.on_bus) fail("bus_rejected_write");
                        if (grant_b) qb[0].seen = 1'b1;
                        else qa[0].seen = 1'b1;
                    end
                end
                if (a_done && b_done) fail("both_done");
                if (a_done) begin
                    chk("a_done_grant", 32'(grant_b), 32'd0);
                    chk("a_release_strobes", 32'(strobe), 32'd0);
                    if (qa.size() == 0) fail("a_done_orphan");
                    else begin
                        e = qa.pop_front();
                        chk("a_data_rx", 32'(a_data_rx), 32'(e.rx));
                        chk("a_bus_seen", 32'(e.seen), 32'(e.on_bus));
                    end
                end
                if (b_done) begin
                    chk("b_done_grant", 32'(grant_b), 32'd1);
                    chk("b_release_strobes", 32'(strobe), 32'd0);
                    if (qb.size() == 0) fail("b_done_orphan");
                    else begin
                        e = qb.pop_front();
                        if (!e.on_bus) service(1'b1, pra, prb);
                        chk("b_data_rx", 32'(b_data_rx), 32'(e.rx));
                        chk("b_bus_seen", 32'(e.seen), 32'(e.on_bus));
                    end
                end
            end
            ps  = strobe;
            pra = a_read | a_write;
            prb = b_read | b_write;
        end
    end

    // Called at posedge+1; returns cycles from request to the done pulse.
    task automatic do_txn(input bit p, input logic [15:0] addr, input logic [7:0] data,
                          input bit rd, input bit wr, output int lat);
        txn_t e;
        bit   rej;
        bit   done;
`ifdef ARB_FLASH_WP_EN
        rej = p && wr && !addr[15];
`else
        rej = 1'b0;
`endif
        e.addr = addr; e.data = data; e.rd = rd; e.wr = wr; e.seen = 1'b0; e.on_bus = !rej;
        if (rej) e.rx = 8'hFF;
        else if (wr) begin
            e.rx = data ^ 8'hA5;
            ref_mem[addr] = data;
        end else e.rx = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
        if (p) begin
            qb.push_back(e);
            b_address = addr; b_data_tx = data; b_read = rd; b_write = wr;
        end else begin
            qa.push_back(e);
            a_address = addr; a_data_tx = data; a_read = rd; a_write = wr;
        end
        lat = 0;
        done = 1'b0;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            done = p ? b_done : a_done;
        end
        if (!done) fail(p ? "b_timeout" : "a_timeout");
        @(posedge clk); #1;
        if (p) begin b_read = 1'b0; b_write = 1'b0; end
        else begin a_read = 1'b0; a_write = 1'b0; end
    endtask

    task automatic rand_op(output bit rd, output bit wr);
        int r;
        r = int'($urandom_range(0, 3));
        rd = (r != 2);
        wr = (r >= 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, l2;
        bit rd, wr;
        rst = 1'b1;
        a_address = '0; a_data_tx = '0; a_read = 1'b0; a_write = 1'b0;
        b_address = '0; b_data_tx = '0; b_read = 1'b0; b_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_done", 32'(a_done), 0);
        chk("rst_b_done", 32'(b_done), 0);
        chk("rst_a_data_rx", 32'(a_data_rx), 0);
        chk("rst_b_data_rx", 32'(b_data_rx), 0);
        chk("rst_bus_read", 32'(bus_read), 0);
        chk("rst_bus_write", 32'(bus_write), 0);
        chk("rst_grant_b", 32'(grant_b), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // CPU read with a slow memory
        bus_mem[16'h8010] = 8'h5A;
        ref_mem[16'h8010] = 8'h5A;
        fixed_lat = 12;
        fork
            do_txn(1'b0, 16'h8010, 8'h00, 1'b1, 1'b0, lat);
            begin
                @(posedge clk); #1;
                chk("t1_bus_read_latency", 32'(bus_read), 1);
            end
        join
        fixed_lat = -1;
        chk("t1_a_data_rx_hold", 32'(a_data_rx), 32'h5A);

        // B write while A idle
        do_txn(1'b1, 16'h8100, 8'h33, 1'b0, 1'b1, lat);
        chk("t3_grant_b", 32'(grant_b), 1);

        // read+write together behaves as a write
        do_txn(1'b0, 16'h8030, 8'h11, 1'b1, 1'b1, lat);

        // starvation: A re-requests back to back while B waits
        grant_log.delete();
        fork
            for (int i = 0; i < 5; i++) do_txn(1'b0, 16'h8000 | 16'(i), 8'h00, 1'b1, 1'b0, lat);
            do_txn(1'b1, 16'h9004, 8'h00, 1'b1, 1'b0, l2);
        join
        if (grant_log.size() < 6) fail("t2_grant_count");
        else for (int k = 0; k < 5; k++) chk($sformatf("t2_grant_%0d", k), 32'(grant_log[k]), 32'(k == 4));
        grant_log.delete();
        fork
            do_txn(1'b0, 16'h8020, 8'h00, 1'b1, 1'b0, lat);
            do_txn(1'b1, 16'h9020, 8'h00, 1'b1, 1'b0, l2);
        join
        if (grant_log.size() < 1) fail("t2_cleared_count");
        else chk("t2_after_clear_a_first", 32'(grant_log[0]), 0);

        // flash-region write from B, then read it back
        do_txn(1'b1, 16'h0200, 8'h77, 1'b0, 1'b1, lat);
`ifdef ARB_FLASH_WP_EN
        chk("t6_wp_latency_le2", 32'(lat <= 2), 1);
        chk("t6_wp_rx", 32'(b_data_rx), 32'hFF);
`else
        chk("t6_pass_rx", 32'(b_data_rx), 32'h77 ^ 32'hA5);
`endif
        do_txn(1'b1, 16'h0200, 8'h00, 1'b1, 1'b0, lat);

        // reset in the middle of GRANT
        mon_en = 1'b0;
        fixed_lat = 30;
        a_address = 16'h8040; a_read = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_pre_bus_read", 32'(bus_read), 1);
        rst = 1'b1; a_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_bus_read", 32'(bus_read), 0);
        chk("t5_bus_write", 32'(bus_write), 0);
        chk("t5_a_done", 32'(a_done), 0);
        chk("t5_b_done", 32'(b_done), 0);
        chk("t5_grant_b", 32'(grant_b), 0);
        chk("t5_a_data_rx", 32'(a_data_rx), 0);
        sc = 0;
        fixed_lat = -1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, 16'h8040, 8'h00, 1'b1, 1'b0, lat);

        // randomized concurrent traffic
        fork
            for (int i = 0; i < 40; i++) begin
                bit r, w;
                int l;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                rand_op(r, w);
                do_txn(1'b0, 16'h8000 | 16'($urandom_range(0, 255)), 8'($urandom), r, w, l);
            end
            for (int i = 0; i < 30; i++) begin
                bit r, w;
                int l;
                logic [15:0] ad;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                rand_op(r, w);
                ad = ($urandom_range(0, 3) == 0) ? (16'h0200 | 16'($urandom_range(0, 15)))
                                                 : (16'h9000 | 16'($urandom_range(0, 255)));
                do_txn(1'b1, ad, 8'($urandom), r, w, l);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("end_qa_empty", 32'(qa.size()), 0);
        chk("end_qb_empty", 32'(qb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
